// File: rtl/apple_iie_mmu_pkg.sv
// Apple IIe MMU shared definitions.
// Holds the soft-switch and status addresses, the switch-state struct
// and the reset values used by the MMU top and the language card.
package apple_iie_mmu_pkg;

    // Soft switches: the even address clears the switch and the odd address sets it.
    localparam logic [15:0] A_80STORE   = 16'hC000;
    localparam logic [15:0] A_RAMRD     = 16'hC002;
    localparam logic [15:0] A_RAMWRT    = 16'hC004;
    localparam logic [15:0] A_INTCXROM  = 16'hC006;
    localparam logic [15:0] A_ALTZP     = 16'hC008;
    localparam logic [15:0] A_SLOTC3ROM = 16'hC00A;
    localparam logic [15:0] A_PAGE2     = 16'hC054;
    localparam logic [15:0] A_HIRES     = 16'hC056;

    // Status read addresses. The state is returned on md7.
    localparam logic [15:0] ST_BANK2     = 16'hC011;
    localparam logic [15:0] ST_LCRAM     = 16'hC012;
    localparam logic [15:0] ST_RAMRD     = 16'hC013;
    localparam logic [15:0] ST_RAMWRT    = 16'hC014;
    localparam logic [15:0] ST_INTCXROM  = 16'hC015;
    localparam logic [15:0] ST_ALTZP     = 16'hC016;
    localparam logic [15:0] ST_SLOTC3ROM = 16'hC017;
    localparam logic [15:0] ST_80STORE   = 16'hC018;
    localparam logic [15:0] ST_PAGE2     = 16'hC01C;
    localparam logic [15:0] ST_HIRES     = 16'hC01D;

    typedef struct packed {
        logic store80;
        logic ramrd;
        logic ramwrt;
        logic altzp;
        logic intcxrom;
        logic slotc3rom;
        logic page2;
        logic hires;
    } sw_t;

    localparam sw_t  SW_RESET     = '0;
    localparam logic LCRAM_RESET  = 1'b0;
    localparam logic WREN_RESET   = 1'b1;
    localparam logic BANK2_RESET  = 1'b1;

endpackage

// File: rtl/apple_iie_mmu_banked_if.sv
// CPU-side access bus and memory-enable outputs of the Apple IIe MMU.
// The master drives cyc_en/a/rw_n/d_in/inh_n. The slave (the MMU) returns the
// enables, cxxx, aux_bank and the md7 status bit.
interface apple_iie_mmu_banked_if #(parameter int BANK_W = 8);
    logic              cyc_en;
    logic [15:0]       a;
    logic              rw_n;
    logic [7:0]        d_in;
    logic              inh_n;
    logic              ramen_n;
    logic              romen_n;
    logic              en80_n;
    logic              cxxx;
    logic [BANK_W-1:0] aux_bank;
    logic              md7;
    logic              md7_oe;

    modport master (output cyc_en, a, rw_n, d_in, inh_n,
                    input  ramen_n, romen_n, en80_n, cxxx, aux_bank, md7, md7_oe);
    modport slave  (input  cyc_en, a, rw_n, d_in, inh_n,
                    output ramen_n, romen_n, en80_n, cxxx, aux_bank, md7, md7_oe);
endinterface

// File: rtl/apple_iie_language_card.sv
// Language card state: LCRAM (read RAM), WREN (write enable), BANK2 and the
// pre-write flag.
// Ports: clk_14m/reset, cyc_en (access strobe), a/rw_n (current access);
//        lcram_o/wren_o/bank2_o (registered state).
// LC_PREWRITE=1 needs two consecutive odd reads to set WREN.
// LC_PREWRITE=0 sets WREN on any odd access.
module apple_iie_language_card
    import apple_iie_mmu_pkg::*;
#(
    parameter bit LC_PREWRITE = 1'b1
) (
    input  logic        clk_14m,
    input  logic        reset,
    input  logic        cyc_en,
    input  logic [15:0] a,
    input  logic        rw_n,
    output logic        lcram_o,
    output logic        wren_o,
    output logic        bank2_o
);
    logic lcram_q, lcram_d, wren_q, wren_d, bank2_q, bank2_d, prew_q, prew_d;
    logic hit;

    assign hit = (a[15:4] == 12'hC08);

    always_comb begin
        lcram_d = lcram_q;
        wren_d  = wren_q;
        bank2_d = bank2_q;
        prew_d  = prew_q;
        if (cyc_en && hit) begin
            bank2_d = ~a[3];
            lcram_d = (a[0] == a[1]);
            if (!a[0]) begin
                wren_d = 1'b0;
                prew_d = 1'b0;
            end else if (LC_PREWRITE) begin
                // An odd write breaks the read pair, so prewrite follows rw_n.
                if (rw_n && prew_q) wren_d = 1'b1;
                prew_d = rw_n;
            end else begin
                wren_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_14m or posedge reset) begin
        if (reset) begin
            lcram_q <= LCRAM_RESET;
            wren_q  <= WREN_RESET;
            bank2_q <= BANK2_RESET;
            prew_q  <= 1'b0;
        end else begin
            lcram_q <= lcram_d;
            wren_q  <= wren_d;
            bank2_q <= bank2_d;
            prew_q  <= prew_d;
        end
    end

    assign lcram_o = lcram_q;
    assign wren_o  = wren_q;
    assign bank2_o = bank2_q;
endmodule

// File: rtl/apple_iie_mmu_banked.sv
// Apple IIe MMU with soft switches, a language card, Cx ROM mapping and a
// RAMWorks-style aux bank register.
// Ports: clk_14m, reset (async, active-high), bus (slave modport). The bus
//        carries cyc_en/a/rw_n/d_in/inh_n in, and
//        ramen_n/romen_n/en80_n/cxxx/aux_bank/md7/md7_oe out.
// Each strobed access is latched. The enables are then decoded combinationally
// from the latched access and the already-updated switch state.
module apple_iie_mmu_banked
    import apple_iie_mmu_pkg::*;
#(
    parameter int          AUX_BANKS     = 1,
    parameter int          BANK_W        = 8,
    parameter bit          LC_PREWRITE   = 1'b1,
    parameter logic [15:0] BANK_REG_ADDR = 16'hC073
) (
    input logic             clk_14m,
    input logic             reset,
    apple_iie_mmu_banked_if.slave bus
);
    sw_t               sw_q, sw_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [15:0]       a_q;
    logic              rw_q, vld_q, md7_q, md7_d, md7_oe_q, md7_oe_d;
    logic              lcram, wren, bank2;

    apple_iie_language_card #(.LC_PREWRITE(LC_PREWRITE)) u_lc (
        .clk_14m (clk_14m),
        .reset   (reset),
        .cyc_en  (bus.cyc_en),
        .a       (bus.a),
        .rw_n    (bus.rw_n),
        .lcram_o (lcram),
        .wren_o  (wren),
        .bank2_o (bank2)
    );

    always_comb begin
        sw_d     = sw_q;
        bank_d   = bank_q;
        md7_d    = md7_q;
        md7_oe_d = 1'b0;
        if (!bus.rw_n) begin
            if (bus.a[15:1] == A_80STORE[15:1])   sw_d.store80   = bus.a[0];
            if (bus.a[15:1] == A_RAMRD[15:1])     sw_d.ramrd     = bus.a[0];
            if (bus.a[15:1] == A_RAMWRT[15:1])    sw_d.ramwrt    = bus.a[0];
            if (bus.a[15:1] == A_INTCXROM[15:1])  sw_d.intcxrom  = bus.a[0];
            if (bus.a[15:1] == A_ALTZP[15:1])     sw_d.altzp     = bus.a[0];
            if (bus.a[15:1] == A_SLOTC3ROM[15:1]) sw_d.slotc3rom = bus.a[0];
            // Out-of-range bank numbers are ignored. A single bank pins the register at 0.
            if (AUX_BANKS > 1 && bus.a == BANK_REG_ADDR && int'(bus.d_in) < AUX_BANKS)
                bank_d = BANK_W'(bus.d_in);
        end
        if (bus.a[15:1] == A_PAGE2[15:1]) sw_d.page2 = bus.a[0];
        if (bus.a[15:1] == A_HIRES[15:1]) sw_d.hires = bus.a[0];
        if (bus.rw_n) begin
            md7_oe_d = 1'b1;
            case (bus.a)
                ST_BANK2:     md7_d = bank2;
                ST_LCRAM:     md7_d = lcram;
                ST_RAMRD:     md7_d = sw_q.ramrd;
                ST_RAMWRT:    md7_d = sw_q.ramwrt;
                ST_INTCXROM:  md7_d = sw_q.intcxrom;
                ST_ALTZP:     md7_d = sw_q.altzp;
                ST_SLOTC3ROM: md7_d = sw_q.slotc3rom;
                ST_80STORE:   md7_d = sw_q.store80;
                ST_PAGE2:     md7_d = sw_q.page2;
                ST_HIRES:     md7_d = sw_q.hires;
                default:      md7_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_14m or posedge reset) begin
        if (reset) begin
            sw_q     <= SW_RESET;
            bank_q   <= '0;
            a_q      <= '0;
            rw_q     <= 1'b1;
            vld_q    <= 1'b0;
            md7_q    <= 1'b0;
            md7_oe_q <= 1'b0;
        end else if (bus.cyc_en) begin
            sw_q     <= sw_d;
            bank_q   <= bank_d;
            a_q      <= bus.a;
            rw_q     <= bus.rw_n;
            vld_q    <= 1'b1;
            md7_q    <= md7_d;
            md7_oe_q <= md7_oe_d;
        end
    end

    // Decode of the latched access
    logic rd_aux, ram_sel, aux_sel, rom_sel, en;

    always_comb begin
        rd_aux  = rw_q ? sw_q.ramrd : sw_q.ramwrt;
        ram_sel = 1'b0;
        aux_sel = 1'b0;
        rom_sel = 1'b0;
        if (a_q < 16'h0200) begin
            ram_sel = 1'b1;
            aux_sel = sw_q.altzp;
        end else if (a_q < 16'hC000) begin
            ram_sel = 1'b1;
            if (a_q[15:10] == 6'b000001)
                aux_sel = sw_q.store80 ? sw_q.page2 : rd_aux;
            else if (a_q[15:13] == 3'b001)
                aux_sel = (sw_q.store80 && sw_q.hires) ? sw_q.page2 : rd_aux;
            else
                aux_sel = rd_aux;
        end else if (a_q[15:12] == 4'hC) begin
            // C3 internal ROM is governed by SLOTC3ROM even when INTCXROM is clear.
            rom_sel = ((a_q[11:8] != 4'h0) && sw_q.intcxrom) ||
                      ((a_q[11:8] == 4'h3) && !sw_q.slotc3rom);
        end else begin
            ram_sel = rw_q ? lcram : wren;
            aux_sel = sw_q.altzp;
            rom_sel = rw_q && !lcram;
        end
    end

    assign en           = vld_q && bus.inh_n;
    assign bus.ramen_n  = !(en && ram_sel && !aux_sel);
    assign bus.en80_n   = !(en && ram_sel && aux_sel);
    assign bus.romen_n  = !(en && rom_sel);
    assign bus.aux_bank = (ram_sel && aux_sel) ? bank_q : '0;
    assign bus.cxxx     = vld_q && (a_q[15:12] == 4'hC);
    assign bus.md7      = md7_q;
    assign bus.md7_oe   = md7_oe_q;
endmodule

// File: tb/tb_apple_iie_mmu_banked.sv
// Scoreboard bench for apple_iie_mmu_banked. DUT A has LC_PREWRITE=1 and
// AUX_BANKS=4. DUT B has LC_PREWRITE=0 and AUX_BANKS=1. Both DUTs see the same
// accesses. Expected results are queued with each access and checked by a
// monitor at the falling edge after the strobe.
module tb_apple_iie_mmu_banked;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apple_iie_mmu_banked_if #(.BANK_W(8)) ifa ();
    apple_iie_mmu_banked_if #(.BANK_W(8)) ifb ();

    apple_iie_mmu_banked #(.AUX_BANKS(4), .BANK_W(8), .LC_PREWRITE(1'b1), .BANK_REG_ADDR(16'hC073))
        dut_a (.clk_14m(clk), .reset(rst), .bus(ifa));
    apple_iie_mmu_banked #(.AUX_BANKS(1), .BANK_W(8), .LC_PREWRITE(1'b0), .BANK_REG_ADDR(16'hC073))
        dut_b (.clk_14m(clk), .reset(rst), .bus(ifb));

    // e = {ramen_n, romen_n, en80_n, cxxx, md7, md7_oe}; m[6:1] masks e, m[0] masks aux_bank
    typedef struct {
        string      nm;
        logic [6:0] m;
        logic [5:0] e;
        logic [7:0] bk;
        bit         cb;
        logic       bram;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    logic pend = 1'b0;

    localparam logic [6:0] MA = 7'h7E;
    localparam logic [6:0] MB = 7'h7F;

    always @(posedge clk) pend <= ifa.cyc_en && !rst;

    always @(negedge clk) begin
        if (pend) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output: no queued expectation");
            end else begin
                exp_t x;
                logic [5:0] got;
                x = q.pop_front();
                got = {ifa.ramen_n, ifa.romen_n, ifa.en80_n, ifa.cxxx, ifa.md7, ifa.md7_oe};
                if (x.m != 7'h0) begin
                    checks++;
                    if ((((got ^ x.e) & x.m[6:1]) != 6'h0) || (x.m[0] && ifa.aux_bank != x.bk)) begin
                        failures++;
                        $display("FAIL %s: got {ramen,romen,en80,cxxx,md7,oe}=%b bank=%0d, want %b bank=%0d (mask %b)",
                                 x.nm, got, ifa.aux_bank, x.e, x.bk, x.m);
                    end
                end
                if (x.cb) begin
                    checks++;
                    if (ifb.ramen_n !== x.bram) begin
                        failures++;
                        $display("FAIL %s_b: ramen_n got %b want %b", x.nm, ifb.ramen_n, x.bram);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic acc(input logic [15:0] addr, input logic rw, input logic [7:0] d,
                       input logic inh, input string nm, input logic [6:0] m,
                       input logic [5:0] e, input logic [7:0] bk,
                       input bit cb = 1'b0, input logic bram = 1'b1);
        exp_t x;
        x.nm = nm; x.m = m; x.e = e; x.bk = bk; x.cb = cb; x.bram = bram;
        @(negedge clk);
        q.push_back(x);
        ifa.a = addr; ifa.rw_n = rw; ifa.d_in = d; ifa.inh_n = inh; ifa.cyc_en = 1'b1;
        ifb.a = addr; ifb.rw_n = rw; ifb.d_in = d; ifb.inh_n = inh; ifb.cyc_en = 1'b1;
        @(negedge clk);
        ifa.cyc_en = 1'b0;
        ifb.cyc_en = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input string nm, input logic [6:0] m,
                      input logic [5:0] e, input logic [7:0] bk = 8'd0);
        acc(addr, 1'b1, 8'h00, 1'b1, nm, m, e, bk);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] d, input string nm,
                      input logic [6:0] m, input logic [5:0] e, input logic [7:0] bk = 8'd0);
        acc(addr, 1'b0, d, 1'b1, nm, m, e, bk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ramen_n"}, 32'(ifa.ramen_n), 32'd1);
        chk({tag, "_romen_n"}, 32'(ifa.romen_n), 32'd1);
        chk({tag, "_en80_n"},  32'(ifa.en80_n),  32'd1);
        chk({tag, "_cxxx"},    32'(ifa.cxxx),    32'd0);
        chk({tag, "_bank"},    32'(ifa.aux_bank), 32'd0);
        chk({tag, "_md7"},     32'(ifa.md7),     32'd0);
        chk({tag, "_md7_oe"},  32'(ifa.md7_oe),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        ifa.cyc_en = 0; ifa.a = 0; ifa.rw_n = 1; ifa.d_in = 0; ifa.inh_n = 1;
        ifb.cyc_en = 0; ifb.a = 0; ifb.rw_n = 1; ifb.d_in = 0; ifb.inh_n = 1;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        rd(16'hFFFC, "rom_fffc",       MB, 6'b101000);
        rd(16'hC011, "stat_bank2_rst", MA, 6'b111111);
        rd(16'hC08A, "lc_c08a",        MA, 6'b111110);
        rd(16'hC08B, "lc_c08b_1",      MA, 6'b111110);
        wr(16'hD000, 8'h00, "wren_one_read", MA, 6'b111010);
        rd(16'hC08B, "lc_c08b_2",      MA, 6'b111110);
        rd(16'hC011, "bank2_clr",      MA, 6'b111101);
        rd(16'hC012, "lcram_set",      MA, 6'b111111);
        wr(16'hD000, 8'h00, "wren_two_reads", MB, 6'b011010);
        rd(16'hD000, "lcram_rd",       MB, 6'b011010);
        rd(16'hC08A, "lc_c08a_2",      MA, 6'b111110);
        rd(16'hC08B, "lc_c08b_3",      MA, 6'b111110);
        wr(16'hC08B, 8'h00, "lc_wr_c08b", MA, 6'b111110);
        rd(16'hC08B, "lc_c08b_4",      MA, 6'b111110);
        wr(16'hD000, 8'h00, "prew_cleared", MA, 6'b111010);
        rd(16'hC08A, "lc_c08a_3",      MA, 6'b111110);
        wr(16'hC089, 8'h00, "lc_wr_c089", MA, 6'b111110);
        acc(16'hD000, 1'b0, 8'h00, 1'b1, "lc_single", MA, 6'b111010, 8'd0, 1'b1, 1'b0);

        wr(16'hC073, 8'd2, "bank_wr2",  MA, 6'b111110);
        wr(16'hC005, 8'd0, "ramwrt_on", MA, 6'b111110);
        wr(16'h4000, 8'd0, "aux_bank2", MB, 6'b110010, 8'd2);
        wr(16'hC073, 8'd5, "bank_wr5",  MA, 6'b111110);
        wr(16'h4000, 8'd0, "bank_hold", MB, 6'b110010, 8'd2);
        rd(16'h4000, "main_rd",         MB, 6'b011010);

        wr(16'hC001, 8'd0, "store80_on", MA, 6'b111110);
        rd(16'hC055, "page2_on",         MA, 6'b111110);
        wr(16'h0400, 8'd0, "store80_page2", MB, 6'b110010, 8'd2);
        wr(16'hC000, 8'd0, "store80_off_sw", MA, 6'b111110);
        wr(16'hC004, 8'd0, "ramwrt_off", MA, 6'b111110);
        wr(16'h0400, 8'd0, "store80_off", MB, 6'b011010);
        rd(16'hC013, "stat_ramrd",       MA, 6'b111101);
        rd(16'hC01C, "stat_page2",       MA, 6'b111111);

        wr(16'hC009, 8'd0, "altzp_on",   MA, 6'b111110);
        rd(16'h0100, "altzp",            MB, 6'b110010, 8'd2);
        rd(16'hC08B, "lc_c08b_5",        MA, 6'b111110);
        rd(16'hE000, "lc_altzp",         MB, 6'b110010, 8'd2);
        wr(16'hC008, 8'd0, "altzp_off",  MA, 6'b111110);

        acc(16'h2000, 1'b1, 8'h00, 1'b0, "inhibit", MA, 6'b111010, 8'd0);
        rd(16'h2000, "inhibit_off",      MB, 6'b011010);
        rd(16'hC300, "c3_int",           MA, 6'b101110);
        wr(16'hC00B, 8'd0, "slotc3_on",  MA, 6'b111110);
        rd(16'hC300, "c3_slot",          MA, 6'b111110);
        rd(16'hC800, "c8_slot",          MA, 6'b111110);
        wr(16'hC007, 8'd0, "intcx_on",   MA, 6'b111110);
        rd(16'hC800, "c8_int",           MA, 6'b101110);

        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset("midreset");
        @(negedge clk);
        rst = 1'b0;
        rd(16'hC011, "post_reset_bank2", MA, 6'b111111);
        rd(16'hFFFC, "post_reset_rom",   MB, 6'b101010);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain: %0d expectations not consumed, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
